// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: valid/ready handshake, flush-to-bubble, saturating
// stall counter. Define PIPE_SKID_EN for a 2-entry skid version with a registered in_ready.

package pipe_stage_pkg;
  typedef struct packed {
    logic ld_main;   // capture into the output register
    logic sel_skid;  // main source: skid entry instead of upstream
    logic clr_main;  // zero output register (bubble)
    logic ld_skid;   // park upstream word in the skid entry
    logic clr_skid;  // drop skid entry
  } lane_ctl_t;
endpackage

module pipe_stage_lane
  import pipe_stage_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         Clk,
  input  logic         Reset,
  input  lane_ctl_t    ctl,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;

`ifdef PIPE_SKID_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)            skid_q <= '0;
    else if (ctl.clr_skid) skid_q <= '0;
    else if (ctl.ld_skid)  skid_q <= din;
  end
`else
  logic unused_skid;
  assign unused_skid = ctl.ld_skid ^ ctl.clr_skid;
  assign skid_q      = '0;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)            main_q <= '0;
    else if (ctl.clr_main) main_q <= '0;
    else if (ctl.ld_main)  main_q <= ctl.sel_skid ? skid_q : din;
  end

  assign dout = main_q;
endmodule

module pipe_stage_reg
  import pipe_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0]        in_ctrl,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [CNT_W-1:0]         stall_count
);
`ifdef PIPE_SKID_EN
  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;
`else
  typedef enum logic {ST_EMPTY, ST_FULL} state_t;
`endif

  state_t    state, state_nxt;
  lane_ctl_t ctl;

  logic [NUM_CH-1:0][DATA_W-1:0] din_ch, dout_ch;
  logic [CNT_W-1:0]              stall_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  // Lanes clear on any transition to empty, so out_* read zero whenever out_valid is low.
  always_comb begin
    state_nxt = state;
    ctl       = '0;
    if (Flush) begin
      state_nxt    = ST_EMPTY;
      ctl.clr_main = 1'b1;
      ctl.clr_skid = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_valid) begin
            ctl.ld_main = 1'b1;
            state_nxt   = ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_valid && out_ready) begin
            ctl.ld_main = 1'b1;
`ifdef PIPE_SKID_EN
          end else if (in_valid) begin
            ctl.ld_skid = 1'b1;
            state_nxt   = ST_SKID;
`endif
          end else if (out_ready) begin
            ctl.clr_main = 1'b1;
            state_nxt    = ST_EMPTY;
          end
        end
`ifdef PIPE_SKID_EN
        ST_SKID: begin
          if (out_ready) begin
            ctl.ld_main  = 1'b1;
            ctl.sel_skid = 1'b1;
            ctl.clr_skid = 1'b1;
            state_nxt    = ST_FULL;
          end
        end
`endif
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  assign out_valid = (state != ST_EMPTY);

`ifdef PIPE_SKID_EN
  // Registered ready: low exactly while the skid entry is occupied.
  logic in_ready_q;
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) in_ready_q <= 1'b1;
    else        in_ready_q <= (state_nxt != ST_SKID);
  end
  assign in_ready = in_ready_q;
`else
  assign in_ready = out_ready || !out_valid;
`endif

  assign din_ch = in_data;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
    pipe_stage_lane #(.W(DATA_W)) u_lane (
      .Clk  (Clk),
      .Reset(Reset),
      .ctl  (ctl),
      .din  (din_ch[ch]),
      .dout (dout_ch[ch])
    );
  end

  pipe_stage_lane #(.W(CTRL_W)) u_ctrl (
    .Clk  (Clk),
    .Reset(Reset),
    .ctl  (ctl),
    .din  (in_ctrl),
    .dout (out_ctrl)
  );

  assign out_data = dout_ch;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                                      stall_q <= '0;
    else if (out_valid && !out_ready && !(&stall_q)) stall_q <= stall_q + 1'b1;
  end

  assign stall_count = stall_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: capacity-bounded FIFO model checked every cycle, plus directed
// scenarios with literal expectations. Works with or without PIPE_SKID_EN.

module tb_pipe_stage_reg;
  localparam int DATA_W = 32;
  localparam int NUM_CH = 4;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;
  localparam int DW     = DATA_W * NUM_CH;
  localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int CAP = SKID ? 2 : 1;

  logic Clk = 1'b0, Reset = 1'b0, Flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [DW-1:0]     in_data = '0, out_data;
  logic [CTRL_W-1:0] in_ctrl = '0, out_ctrl;
  logic [CNT_W-1:0]  stall_count;

  pipe_stage_reg #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_count(stall_count)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [DW-1:0]     d;
    logic [CTRL_W-1:0] c;
  } bund_t;

  bund_t       q[$];
  int unsigned m_cnt = 0;
  bit          last_in_x = 1'b0;
  int          total = 0, bad = 0;

  // Stage is a FIFO of depth CAP; without skid it may also accept when the head leaves.
  function automatic bit m_ready();
    return (q.size() < CAP) || (!SKID && out_ready);
  endfunction

  task automatic model_clear();
    q.delete();
    m_cnt = 0;
  endtask

  task automatic model_edge();
    bit    ix, ox;
    bund_t b, tmp;
    last_in_x = 1'b0;
    if (!Reset) begin
      model_clear();
      return;
    end
    ix = in_valid && m_ready();
    ox = (q.size() > 0) && out_ready;
    if (q.size() > 0 && !out_ready && m_cnt < CMAX) m_cnt++;
    if (Flush) q.delete();
    else begin
      if (ox) tmp = q.pop_front();
      if (ix) begin
        b.d = in_data;
        b.c = in_ctrl;
        q.push_back(b);
      end
      last_in_x = ix;
    end
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic pulse_reset();
    #2;
    Reset = 1'b0;
    model_clear();
    @(posedge Clk);
    model_edge();
    #1;
    Reset = 1'b1;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge Clk);
    chk("out_valid", DW'(out_valid), DW'(q.size() > 0));
    chk("out_data", out_data, (q.size() > 0) ? q[0].d : '0);
    chk("out_ctrl", DW'(out_ctrl), (q.size() > 0) ? DW'(q[0].c) : '0);
    chk("in_ready", DW'(in_ready), DW'(m_ready()));
    chk("stall_count", DW'(stall_count), DW'(m_cnt));
  end

  initial begin
    // reset state
    repeat (2) cycle();
    chk("rst_valid", DW'(out_valid), '0);
    chk("rst_ctrl", DW'(out_ctrl), '0);
    chk("rst_data", out_data, '0);
    chk("rst_cnt", DW'(stall_count), '0);
    Reset = 1'b1;
    chk("rst_ready", DW'(in_ready), DW'(1));

    // stream 8 bundles at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom, $urandom, 32'h1000 + i};
      in_ctrl  = 8'h81;
      chk("s2_ready", DW'(in_ready), DW'(1));
      cycle();
      chk("s2_data", DW'(out_data[31:0]), DW'(32'h1000 + i));
      chk("s2_ctrl", DW'(out_ctrl), DW'(8'h81));
    end
    in_valid = 1'b0;
    cycle();

    // async reset mid-stream while stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {$urandom, $urandom, $urandom, $urandom};
    in_ctrl   = 8'h5A;
    cycle();
    in_valid = 1'b0;
    repeat (2) cycle();
    chk("s1_cnt_pre", DW'(stall_count), DW'(2));
    #2;
    Reset = 1'b0;
    model_clear();
    #1;
    chk("s1_valid", DW'(out_valid), '0);
    chk("s1_ctrl", DW'(out_ctrl), '0);
    chk("s1_cnt", DW'(stall_count), '0);
    @(posedge Clk);
    model_edge();
    #1;
    Reset = 1'b1;
    chk("s1_ready", DW'(in_ready), DW'(1));

    // stall with a second bundle waiting
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom, $urandom, 32'hDEADBEEF};
    in_ctrl  = 8'h3C;
    cycle();
    in_data = {$urandom, $urandom, $urandom, 32'hCAFEF00D};
    in_ctrl = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (last_in_x) in_valid = 1'b0;
    end
    chk("s3_hold", DW'(out_data[31:0]), DW'(32'hDEADBEEF));
    chk("s3_hold_ctrl", DW'(out_ctrl), DW'(8'h3C));
    chk("s3_cnt", DW'(stall_count), DW'(5));
    chk("s3_ready", DW'(in_ready), '0);
    out_ready = 1'b1;
    #1;
    chk("s3_ready_follow", DW'(in_ready), DW'(!SKID));
    cycle();
    if (last_in_x) in_valid = 1'b0;
    chk("s3_second", DW'(out_data[31:0]), DW'(32'hCAFEF00D));
    chk("s3_second_ctrl", DW'(out_ctrl), DW'(8'hC3));
    cycle();
    chk("s3_drained", DW'(out_valid), '0);

    // flush wins over a simultaneous input transfer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {$urandom, $urandom, $urandom, 32'h11};
    cycle();
    Flush   = 1'b1;
    in_data = {$urandom, $urandom, $urandom, 32'h55};
    in_ctrl = 8'hFF;
    cycle();
    Flush    = 1'b0;
    in_valid = 1'b0;
    chk("s4_valid", DW'(out_valid), '0);
    chk("s4_ctrl", DW'(out_ctrl), '0);
    chk("s4_data", out_data, '0);
    chk("s4_cnt_kept", DW'(stall_count), DW'(6));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("s4_no55", DW'(out_data[31:0] == 32'h55), '0);
    end

    // stall counter saturation
    pulse_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {$urandom, $urandom, $urandom, $urandom};
    cycle();
    in_valid = 1'b0;
    repeat (20) cycle();
    chk("s5_sat", DW'(stall_count), DW'(15));
    out_ready = 1'b1;
    cycle();

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_ctrl   = CTRL_W'($urandom);
      out_ready = (k % 600 < 300) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      Flush     = ($urandom_range(40) == 0);
      if ($urandom_range(400) == 0) pulse_reset();
      cycle();
    end
    Flush    = 1'b0;
    in_valid = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
